// File: rtl/risc_v_mike_mem_bus.sv
// Registered load/store bus controller: decodes a request to one of NUM_REGIONS targets, waits for its ack, returns one response.
// Optional feature macro MEM_BUS_TIMEOUT_EN enables the ACCESS wait-state timeout counter and timeout error.
module risc_v_mike_mem_bus #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {32'hFFFF0000, 32'h00400000, 32'h7FFF0000, 32'h10010000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {32'hFFFFFF00, 32'hFFC00000, 32'hFFFF0000, 32'hFFFF0000},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_req,
  input  logic                          m_we,
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [DATA_W-1:0]             m_wdata,
  input  logic [DATA_W/8-1:0]           m_be,
  output logic                          m_ready,
  output logic                          m_rsp_valid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic [NUM_REGIONS-1:0]        t_sel,
  output logic                          t_we,
  output logic [ADDR_W-1:0]             t_addr,
  output logic [DATA_W-1:0]             t_wdata,
  output logic [DATA_W/8-1:0]           t_be,
  input  logic [NUM_REGIONS-1:0]        t_ack,
  input  logic [NUM_REGIONS*DATA_W-1:0] t_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   next_state_s;
  logic [NUM_REGIONS-1:0]   hit_s;
  logic [NUM_REGIONS-1:0]   hit_sel_s;
  logic                     dec_err_s;
  logic                     ack_s;
  logic                     timeout_s;
  logic [DATA_W-1:0]        sel_rdata_s;

  logic                     m_ready_r;
  logic                     m_rsp_valid_r;
  logic [DATA_W-1:0]        m_rdata_r;
  logic                     m_err_r;
  logic [NUM_REGIONS-1:0]   t_sel_r;
  logic                     t_we_r;
  logic [ADDR_W-1:0]        t_addr_r;
  logic [DATA_W-1:0]        t_wdata_r;
  logic [BE_W-1:0]          t_be_r;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_hit
    assign hit_s[i] = ((m_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]);
  end

  // Isolate the lowest set hit bit so index 0 has the highest priority.
  assign hit_sel_s = hit_s & (~hit_s + NUM_REGIONS'(1));
  assign dec_err_s = (hit_s == {NUM_REGIONS{1'b0}}) || ((m_addr & ALIGN_MASK) != {ADDR_W{1'b0}});
  assign ack_s     = |(t_ack & t_sel_r);

  // Select the read data of the currently addressed target.
  always_comb begin
    sel_rdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      sel_rdata_s = sel_rdata_s | (t_rdata[i*DATA_W +: DATA_W] & {DATA_W{t_sel_r[i]}});
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_r;

  // Saturating count of ACCESS cycles spent without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_ACCESS) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (!ack_s && (wait_cnt_r != CNT_MAX)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (wait_cnt_r == CNT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an ack in the timeout cycle still completes normally.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (m_req) begin
          next_state_s = dec_err_s ? ST_RESP : ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ack_s || timeout_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Registered request latch, target select and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready_r     <= 1'b0;
      m_rsp_valid_r <= 1'b0;
      m_rdata_r     <= {DATA_W{1'b0}};
      m_err_r       <= 1'b0;
      t_sel_r       <= {NUM_REGIONS{1'b0}};
      t_we_r        <= 1'b0;
      t_addr_r      <= {ADDR_W{1'b0}};
      t_wdata_r     <= {DATA_W{1'b0}};
      t_be_r        <= {BE_W{1'b0}};
    end else begin
      m_ready_r     <= (next_state_s == ST_IDLE);
      m_rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (m_req) begin
            t_we_r    <= m_we;
            t_addr_r  <= m_addr;
            t_wdata_r <= m_wdata;
            t_be_r    <= m_be;
            if (dec_err_s) begin
              t_sel_r       <= {NUM_REGIONS{1'b0}};
              m_rsp_valid_r <= 1'b1;
              m_rdata_r     <= {DATA_W{1'b0}};
              m_err_r       <= 1'b1;
            end else begin
              t_sel_r <= hit_sel_s;
            end
          end else begin
            t_sel_r <= {NUM_REGIONS{1'b0}};
          end
        end
        ST_ACCESS: begin
          if (ack_s) begin
            t_sel_r       <= {NUM_REGIONS{1'b0}};
            m_rsp_valid_r <= 1'b1;
            m_rdata_r     <= t_we_r ? {DATA_W{1'b0}} : sel_rdata_s;
            m_err_r       <= 1'b0;
          end else if (timeout_s) begin
            t_sel_r       <= {NUM_REGIONS{1'b0}};
            m_rsp_valid_r <= 1'b1;
            m_rdata_r     <= {DATA_W{1'b0}};
            m_err_r       <= 1'b1;
          end else begin
            t_sel_r <= t_sel_r;
          end
        end
        ST_RESP: t_sel_r <= {NUM_REGIONS{1'b0}};
        default: t_sel_r <= {NUM_REGIONS{1'b0}};
      endcase
    end
  end

  assign m_ready     = m_ready_r;
  assign m_rsp_valid = m_rsp_valid_r;
  assign m_rdata     = m_rdata_r;
  assign m_err       = m_err_r;
  assign t_sel       = t_sel_r;
  assign t_we        = t_we_r;
  assign t_addr      = t_addr_r;
  assign t_wdata     = t_wdata_r;
  assign t_be        = t_be_r;

endmodule

// File: tb/tb_risc_v_mike_mem_bus.sv
// Directed self-checking bench for risc_v_mike_mem_bus (default region map, DATA_W = 32).
// Timeout scenarios run when MEM_BUS_TIMEOUT_EN is defined; otherwise an unbounded stall is checked.
module tb_risc_v_mike_mem_bus;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_be;
  logic         m_ready;
  logic         m_rsp_valid;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   t_sel;
  logic         t_we;
  logic [31:0]  t_addr;
  logic [31:0]  t_wdata;
  logic [3:0]   t_be;
  logic [3:0]   t_ack;
  logic [127:0] t_rdata;

  int checks = 0;
  int failures = 0;

  risc_v_mike_mem_bus dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ready(m_ready), .m_rsp_valid(m_rsp_valid),
    .m_rdata(m_rdata), .m_err(m_err), .t_sel(t_sel), .t_we(t_we), .t_addr(t_addr),
    .t_wdata(t_wdata), .t_be(t_be), .t_ack(t_ack), .t_rdata(t_rdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
    t_ack = 4'h0;
    t_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    tick(); tick();
    checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%b expected=0", m_ready); end
    checks++; if (t_sel !== 4'b0000) begin failures++; $display("FAIL reset_tsel actual=%b expected=0000", t_sel); end
    checks++; if (m_rsp_valid !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp actual=%b/%b/%h expected=0/0/0", m_rsp_valid, m_err, m_rdata); end
    checks++; if (t_addr !== 32'h0 || t_we !== 1'b0 || t_wdata !== 32'h0 || t_be !== 4'h0) begin failures++; $display("FAIL reset_tbus actual=%h/%b/%h/%h expected=0", t_addr, t_we, t_wdata, t_be); end
    rst = 1'b0;
    tick();
    checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready actual=%b expected=1", m_ready); end
  endtask

  task automatic test_read_data();
    start_req(1'b0, 32'h10010004, 32'h0, 4'hF);
    tick();
    m_req = 1'b0;
    checks++; if (t_sel !== 4'b0001) begin failures++; $display("FAIL read_tsel actual=%b expected=0001", t_sel); end
    checks++; if (t_addr !== 32'h10010004 || t_we !== 1'b0) begin failures++; $display("FAIL read_taddr actual=%h/%b expected=10010004/0", t_addr, t_we); end
    checks++; if (m_rsp_valid !== 1'b0 || m_ready !== 1'b0) begin failures++; $display("FAIL read_c1_ctl actual=%b/%b expected=0/0", m_rsp_valid, m_ready); end
    t_ack = 4'b0001;
    tick();
    t_ack = 4'b0000;
    checks++; if (m_rsp_valid !== 1'b1) begin failures++; $display("FAIL read_rsp_valid actual=%b expected=1", m_rsp_valid); end
    checks++; if (m_rdata !== 32'hDEADBEEF || m_err !== 1'b0) begin failures++; $display("FAIL read_rdata actual=%h/%b expected=deadbeef/0", m_rdata, m_err); end
    checks++; if (t_sel !== 4'b0000 || m_ready !== 1'b0) begin failures++; $display("FAIL read_c2_sel actual=%b/%b expected=0000/0", t_sel, m_ready); end
    tick();
    checks++; if (m_rsp_valid !== 1'b0 || m_ready !== 1'b1) begin failures++; $display("FAIL read_c3 actual=%b/%b expected=0/1", m_rsp_valid, m_ready); end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [2];
    addrs[0] = 32'h20000000;
    addrs[1] = 32'h10010002;
    for (int k = 0; k < 2; k++) begin
      start_req(1'b0, addrs[k], 32'h0, 4'hF);
      tick();
      m_req = 1'b0;
      checks++; if (m_rsp_valid !== 1'b1 || m_err !== 1'b1) begin failures++; $display("FAIL decerr_rsp addr=%h actual=%b/%b expected=1/1", addrs[k], m_rsp_valid, m_err); end
      checks++; if (m_rdata !== 32'h0 || t_sel !== 4'b0000) begin failures++; $display("FAIL decerr_data addr=%h actual=%h/%b expected=0/0000", addrs[k], m_rdata, t_sel); end
      tick();
      checks++; if (m_rsp_valid !== 1'b0 || t_sel !== 4'b0000 || m_ready !== 1'b1) begin failures++; $display("FAIL decerr_after addr=%h actual=%b/%b/%b expected=0/0000/1", addrs[k], m_rsp_valid, t_sel, m_ready); end
    end
  endtask

  task automatic test_write_mmio();
    start_req(1'b1, 32'hFFFF0010, 32'h0000005A, 4'b0001);
    tick();
    m_req = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_we = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (t_sel !== 4'b1000 || m_rsp_valid !== 1'b0) begin failures++; $display("FAIL write_sel c=%0d actual=%b/%b expected=1000/0", c, t_sel, m_rsp_valid); end
      checks++; if (t_we !== 1'b1 || t_addr !== 32'hFFFF0010 || t_wdata !== 32'h5A || t_be !== 4'b0001) begin failures++; $display("FAIL write_bus c=%0d actual=%b/%h/%h/%b expected=1/ffff0010/5a/0001", c, t_we, t_addr, t_wdata, t_be); end
      t_ack = (c == 4) ? 4'b1000 : ((c == 2) ? 4'b0001 : 4'b0000);
      tick();
    end
    t_ack = 4'b0000;
    checks++; if (m_rsp_valid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h0) begin failures++; $display("FAIL write_rsp actual=%b/%b/%h expected=1/0/0", m_rsp_valid, m_err, m_rdata); end
    tick();
    checks++; if (m_rsp_valid !== 1'b0 || m_ready !== 1'b1) begin failures++; $display("FAIL write_after actual=%b/%b expected=0/1", m_rsp_valid, m_ready); end
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    start_req(1'b0, 32'h7FFF0000, 32'h0, 4'hF);
    tick();
    m_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (m_rsp_valid !== 1'b0 || t_sel !== 4'b0010) early++;
      tick();
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL timeout_wait bad_cycles actual=%0d expected=0", early); end
    checks++; if (m_rsp_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rsp actual=%b/%b/%h expected=1/1/0", m_rsp_valid, m_err, m_rdata); end
    tick();
    t_ack = 4'b0010;
    checks++; if (m_rsp_valid !== 1'b0 || m_ready !== 1'b1) begin failures++; $display("FAIL timeout_c18 actual=%b/%b expected=0/1", m_rsp_valid, m_ready); end
    tick();
    t_ack = 4'b0000;
    checks++; if (m_rsp_valid !== 1'b0 || t_sel !== 4'b0000) begin failures++; $display("FAIL timeout_late_ack actual=%b/%b expected=0/0000", m_rsp_valid, t_sel); end
  endtask

  task automatic test_timeout_boundary();
    start_req(1'b0, 32'h7FFF0004, 32'h0, 4'hF);
    tick();
    m_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      t_ack = (c == 16) ? 4'b0010 : 4'b0000;
      tick();
    end
    t_ack = 4'b0000;
    checks++; if (m_rsp_valid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h11111111) begin failures++; $display("FAIL boundary_rsp actual=%b/%b/%h expected=1/0/11111111", m_rsp_valid, m_err, m_rdata); end
    tick();
  endtask
`else
  task automatic test_long_stall();
    int early = 0;
    start_req(1'b0, 32'h7FFF0004, 32'h0, 4'hF);
    tick();
    m_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (m_rsp_valid !== 1'b0 || t_sel !== 4'b0010) early++;
      tick();
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL stall_wait bad_cycles actual=%0d expected=0", early); end
    t_ack = 4'b0010;
    tick();
    t_ack = 4'b0000;
    checks++; if (m_rsp_valid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h11111111) begin failures++; $display("FAIL stall_rsp actual=%b/%b/%h expected=1/0/11111111", m_rsp_valid, m_err, m_rdata); end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    start_req(1'b0, 32'h10010008, 32'h0, 4'hF);
    tick();
    t_ack = 4'b0001;
    tick();
    t_ack = 4'b0000;
    m_addr = 32'h00400010;
    checks++; if (m_rsp_valid !== 1'b1 || m_rdata !== 32'hDEADBEEF || m_ready !== 1'b0) begin failures++; $display("FAIL b2b_first actual=%b/%h/%b expected=1/deadbeef/0", m_rsp_valid, m_rdata, m_ready); end
    tick();
    checks++; if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0 || t_sel !== 4'b0000) begin failures++; $display("FAIL b2b_idle actual=%b/%b/%b expected=1/0/0000", m_ready, m_rsp_valid, t_sel); end
    tick();
    m_req = 1'b0;
    checks++; if (t_sel !== 4'b0100 || t_addr !== 32'h00400010) begin failures++; $display("FAIL b2b_second_sel actual=%b/%h expected=0100/00400010", t_sel, t_addr); end
    t_ack = 4'b0100;
    tick();
    t_ack = 4'b0000;
    checks++; if (m_rsp_valid !== 1'b1 || m_rdata !== 32'h22222222 || m_err !== 1'b0) begin failures++; $display("FAIL b2b_second_rsp actual=%b/%h/%b expected=1/22222222/0", m_rsp_valid, m_rdata, m_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 32'h00400000, 32'h0, 4'hF);
    tick();
    m_req = 1'b0;
    tick();
    checks++; if (t_sel !== 4'b0100) begin failures++; $display("FAIL rstmid_sel_before actual=%b expected=0100", t_sel); end
    rst = 1'b1;
    #1;
    checks++; if (t_sel !== 4'b0000 || m_rsp_valid !== 1'b0 || m_ready !== 1'b0) begin failures++; $display("FAIL rstmid_async actual=%b/%b/%b expected=0000/0/0", t_sel, m_rsp_valid, m_ready); end
    tick();
    rst = 1'b0;
    t_ack = 4'b0100;
    tick();
    t_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0 || t_sel !== 4'b0000) begin failures++; $display("FAIL rstmid_release actual=%b/%b/%b expected=1/0/0000", m_ready, m_rsp_valid, t_sel); end
    tick();
    checks++; if (m_rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp actual=%b expected=0", m_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_read_data();
    test_decode_err();
    test_write_mmio();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
    test_timeout_boundary();
`else
    test_long_stall();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_v_mike_mem_bus.md
# risc_v_mike_mem_bus

Parametrised, registered memory-bus controller between the core's load/store port and up to NUM_REGIONS memory-mapped targets (data, stack, text, MMIO). It decodes each request against per-region base/mask pairs and drives the one selected target. It waits for a per-target acknowledge, so targets may insert any number of wait states. It then returns one response with read data or an error flag.

## Interface
Parameters:
- NUM_REGIONS, 4, number of target regions. Index 0 has the highest decode priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width, a multiple of 8.
- REGION_BASE, {32'hFFFF0000, 32'h00400000, 32'h7FFF0000, 32'h10010000}, packed NUM_REGIONS*ADDR_W. Region i occupies slice [i*ADDR_W +: ADDR_W].
- REGION_MASK, {32'hFFFFFF00, 32'hFFC00000, 32'hFFFF0000, 32'hFFFF0000}, packed NUM_REGIONS*ADDR_W.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without an ack before an error is raised (≥1).

Ports:
- clk  in  1  clock. All flops are rising-edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  1  request from the master.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  byte address.
- m_wdata  in  DATA_W  write data.
- m_be  in  DATA_W/8  byte enables.
- m_ready  out  1  request accepted this cycle (high only in IDLE).
- m_rsp_valid  out  1  one-cycle response pulse, issued for reads and writes.
- m_rdata  out  DATA_W  read data, valid with m_rsp_valid.
- m_err  out  1  error, valid with m_rsp_valid.
- t_sel  out  NUM_REGIONS  one-hot target select.
- t_we, t_addr, t_wdata, t_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the accepted request.
- t_ack  in  NUM_REGIONS  per-target completion.
- t_rdata  in  NUM_REGIONS*DATA_W  per-target read data, target i in slice [i*DATA_W +: DATA_W].

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. Reset enters IDLE.
- IDLE:
  - m_ready = 1.
  - When m_req = 1, latch m_we, m_addr, m_wdata and m_be.
  - A region hits when (m_addr & MASK[i]) == BASE[i]. The lowest hitting index wins.
- Decode error: no region hits, or m_addr is not aligned to DATA_W/8 bytes.
  - Go to RESP with err = 1 and rdata = 0.
  - t_sel stays 0, so no target is touched.
- Decode hit: store the one-hot index, clear the wait counter, go to ACCESS.
- ACCESS:
  - t_sel[idx] = 1 and the t_* buses hold the latched request stably for the whole state.
  - t_ack bits of unselected targets are ignored.
  - On t_ack[idx]: capture t_rdata[idx] (captured data is 0 for a write), set err = 0, go to RESP.
  - Otherwise increment the wait counter. Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates, never wrapping.
- RESP: m_rsp_valid = 1 for exactly one cycle, then return to IDLE. m_ready = 0 in this state.
- m_rdata and m_err hold their value until the next response. They are meaningful only while m_rsp_valid = 1.
- m_req outside IDLE is ignored. The master must hold m_req until m_ready.
- Reset asserted mid-transaction: the state goes to IDLE immediately, t_sel drops asynchronously, and no response is issued for the aborted access.

## Timing
- Reset values:
  - State is IDLE.
  - t_sel, t_we, t_addr, t_wdata, t_be, m_rsp_valid, m_rdata, m_err and the counter are all 0.
  - m_ready = 0 while rst is high, and 1 in the first cycle after release.
- Accept edge = cycle 0.
  - t_sel is asserted in cycle 1.
  - An ack in cycle 1 produces m_rsp_valid in cycle 2. That is the minimum latency: 2 cycles, and one transaction per 3 cycles.
  - Each cycle of ack delay adds one cycle.
- Decode error: m_rsp_valid in cycle 1.
- Timeout: after TIMEOUT_CYCLES ACCESS cycles without ack, m_rsp_valid fires with err = 1 on the next cycle.
- If the ack arrives in the same cycle the timeout is reached, the ack wins and err = 0.
- A late ack arriving after a timeout is ignored.

## Configuration
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined: the timeout counter and timeout error are active, as described above.
- Undefined:
  - The counter is removed.
  - ACCESS waits indefinitely for t_ack[idx].
  - m_err is raised only for decode errors.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Read from data region: m_addr = 0x10010004, t_ack[0] in cycle 1 with t_rdata[0] = 0xDEADBEEF. Expect t_sel = 4'b0001 in cycle 1, then m_rsp_valid, m_rdata = 0xDEADBEEF and m_err = 0 in cycle 2.
- Write to MMIO with 3 wait states: m_addr = 0xFFFF0010, m_wdata = 0x5A, m_be = 4'b0001, ack in cycle 4. Expect t_sel = 4'b1000 and stable t_* buses for cycles 1-4, then the response in cycle 5 with m_err = 0.
- Unmapped and misaligned addresses: 0x20000000 and 0x10010002. Each gives a response in cycle 1 with m_err = 1, m_rdata = 0, and t_sel = 0 throughout.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): read from 0x7FFF0000 with no ack. Expect the response with m_err = 1 at cycle 17. A late t_ack[1] at cycle 18 produces no second response.
- Ack on the timeout boundary: ack arrives exactly at the 16th ACCESS cycle. Expect m_err = 0 with the captured data.
- Reset in ACCESS: assert rst in cycle 2 of a stalled text-region read at 0x00400000. Expect t_sel = 0 immediately, no m_rsp_valid, and m_ready = 1 one cycle after release.
